// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter (fetch port I, data port D).
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} memarb_state_t;
   typedef enum logic {PORT_I, PORT_D} memarb_port_t;

endpackage

// File: rtl/memarb_pick.sv
// Winner selection between the fetch and data requesters.
// Build option: MEMARB_RR_EN selects round-robin tie breaking; otherwise D wins.
module memarb_pick
   import mem_arb_pkg::*;
(
   input  logic         i_req_i,
   input  logic         d_req_i,
`ifdef MEMARB_RR_EN
   input  memarb_port_t last_i,
`endif
   output logic         valid_o,
   output memarb_port_t port_o
);

   // Pick a winner whenever anyone asks; only a tie consults the policy.
   always_comb begin
      valid_o = i_req_i | d_req_i;
      port_o  = d_req_i ? PORT_D : PORT_I;
`ifdef MEMARB_RR_EN
      if (i_req_i && d_req_i) begin
         port_o = (last_i == PORT_D) ? PORT_I : PORT_D;
      end
`endif
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one word-addressed memory between an instruction fetch port (I)
// and a load/store port (D). Each capture yields exactly one ACCESS cycle
// followed by a RESP cycle carrying the response pulse.
// Build option: MEMARB_RR_EN enables round-robin arbitration on ties.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_req,
   input  logic [WIDTH-1:0] i_addr,
   output logic             i_gnt,
   output logic             i_rvalid,
   output logic [WIDTH-1:0] i_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic             d_gnt,
   output logic             d_rvalid,
   output logic [WIDTH-1:0] d_rdata,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_a,
   output logic [WIDTH-1:0] mem_wd,
   input  logic [WIDTH-1:0] mem_rd
);

   memarb_state_t    state_q, state_d;
   memarb_port_t     owner_q, owner_d;
   logic             we_q, we_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] i_rdata_q, i_rdata_d;
   logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic             pick_valid;
   memarb_port_t     pick_port;

`ifdef MEMARB_RR_EN
   memarb_port_t     last_q, last_d;
`endif

   memarb_pick u_pick (
      .i_req_i (i_req),
      .d_req_i (d_req),
`ifdef MEMARB_RR_EN
      .last_i  (last_q),
`endif
      .valid_o (pick_valid),
      .port_o  (pick_port)
   );

   // State, command latch and response data registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= PORT_I;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

`ifdef MEMARB_RR_EN
   // Last-granted port; starts at D so the first tie goes to I.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) last_q <= PORT_D;
      else       last_q <= last_d;
   end
`endif

   // Next state: capture a new command from IDLE or RESP, access, respond.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
`ifdef MEMARB_RR_EN
      last_d    = last_q;
`endif
      case (state_q)
         IDLE, RESP: begin
            state_d = IDLE;
            if (pick_valid) begin
               state_d = ACCESS;
               owner_d = pick_port;
`ifdef MEMARB_RR_EN
               last_d  = pick_port;
`endif
               if (pick_port == PORT_D) begin
                  we_d    = d_we;
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
               end else begin
                  // Fetches never write; store data is left as it was.
                  we_d    = 1'b0;
                  addr_d  = i_addr;
               end
            end
         end
         ACCESS: begin
            state_d = RESP;
            if (!we_q) begin
               if (owner_q == PORT_D) d_rdata_d = mem_rd;
               else                   i_rdata_d = mem_rd;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake and memory strobes are pure state decodes, so reset kills them at once.
   always_comb begin
      i_gnt    = (state_q == ACCESS) && (owner_q == PORT_I);
      d_gnt    = (state_q == ACCESS) && (owner_q == PORT_D);
      i_rvalid = (state_q == RESP)   && (owner_q == PORT_I);
      d_rvalid = (state_q == RESP)   && (owner_q == PORT_D);
      mem_we   = (state_q == ACCESS) && we_q;
   end

   assign mem_a   = addr_q;
   assign mem_wd  = wdata_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences and
// a randomized run against a transaction-level reference model.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, i_gnt, i_rvalid;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        mem_we;
   logic [31:0] mem_a, mem_wd, mem_rd;

   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];

   int vec_cnt = 0;
   int err_cnt = 0;
   memarb_port_t rr_last;
   logic [31:0] i_hold, d_hold;

   mem_arbiter #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   // Environment memory: combinational read, write on the rising edge.
   assign mem_rd = mem[mem_a[9:2]];
   always @(posedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic memarb_port_t tie_winner(input memarb_port_t last);
`ifdef MEMARB_RR_EN
      return (last == PORT_D) ? PORT_I : PORT_D;
`else
      return (last == PORT_D) ? PORT_D : PORT_D;
`endif
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      rr_last = PORT_D;
      i_hold = '0; d_hold = '0;
   endtask

   // One isolated transaction from IDLE with cycle-exact checks.
   task automatic txn(input bit pd, input bit we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp);
      @(negedge clk);
      if (pd) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; end
      else    begin i_req = 1'b1; i_addr = addr; end
      @(negedge clk);
      chk("txn_gnt",       pd ? d_gnt : i_gnt, 1);
      chk("txn_other_gnt", pd ? i_gnt : d_gnt, 0);
      chk("txn_mem_we",    mem_we, we);
      chk("txn_mem_a",     mem_a, addr);
      if (we) chk("txn_mem_wd", mem_wd, wd);
      chk("txn_rvalid_early", i_rvalid | d_rvalid, 0);
      i_req = 1'b0; d_req = 1'b0;
      rr_last = pd ? PORT_D : PORT_I;
      @(negedge clk);
      chk("txn_rvalid",       pd ? d_rvalid : i_rvalid, 1);
      chk("txn_other_rvalid", pd ? i_rvalid : d_rvalid, 0);
      chk("txn_resp_we",      mem_we, 0);
      chk("txn_resp_gnt",     i_gnt | d_gnt, 0);
      if (!we) begin
         if (pd) d_hold = exp; else i_hold = exp;
      end
      chk("txn_i_rdata", i_rdata, i_hold);
      chk("txn_d_rdata", d_rdata, d_hold);
   endtask

   // Both ports request together from IDLE: I fetches 0x00, D loads 0x20.
   task automatic tie();
      memarb_port_t w, l;
      w = tie_winner(rr_last);
      l = (w == PORT_D) ? PORT_I : PORT_D;
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      @(negedge clk);
      chk("tie_first_i_gnt", i_gnt, w == PORT_I);
      chk("tie_first_d_gnt", d_gnt, w == PORT_D);
      if (w == PORT_D) d_req = 1'b0; else i_req = 1'b0;
      @(negedge clk);
      chk("tie_first_rvalid", (w == PORT_D) ? d_rvalid : i_rvalid, 1);
      @(negedge clk);
      chk("tie_second_i_gnt", i_gnt, l == PORT_I);
      chk("tie_second_d_gnt", d_gnt, l == PORT_D);
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      chk("tie_second_rvalid", (l == PORT_D) ? d_rvalid : i_rvalid, 1);
      chk("tie_i_rdata", i_rdata, 32'h20020005);
      chk("tie_d_rdata", d_rdata, 32'hDEADBEEF);
      i_hold = 32'h20020005; d_hold = 32'hDEADBEEF;
      rr_last = l;
   endtask

   typedef struct {
      bit          port_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [8];

   // Random-phase state
   bit           rv_due, rv_we, gi, gd;
   memarb_port_t rv_port, w, ew;
   logic [31:0]  rv_addr, rv_wd;

   initial begin
      reset = 1'b1;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      for (int k = 0; k < 256; k++) mem[k] = 32'h0;
      mem[0] = 32'h20020005;
      for (int k = 0; k < 4; k++) mem[64 + k] = 32'h1111_0000 + 32'(k);
      rr_last = PORT_D; i_hold = '0; d_hold = '0;

      tbl[0] = '{1, 1, 32'h20, 32'hDEADBEEF, 32'h0};
      tbl[1] = '{1, 0, 32'h20, 32'h0,        32'hDEADBEEF};
      tbl[2] = '{0, 0, 32'h00, 32'h0,        32'h20020005};
      tbl[3] = '{1, 1, 32'h43, 32'hA5A50F0F, 32'h0};
      tbl[4] = '{1, 0, 32'h40, 32'h0,        32'hA5A50F0F};
      tbl[5] = '{0, 0, 32'h42, 32'h0,        32'hA5A50F0F};
      tbl[6] = '{1, 1, 32'h7C, 32'h12345678, 32'h0};
      tbl[7] = '{1, 0, 32'h7C, 32'h0,        32'h12345678};

      // Reset values
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_i_gnt", i_gnt, 0);     chk("rst_d_gnt", d_gnt, 0);
      chk("rst_i_rvalid", i_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_i_rdata", i_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
      chk("rst_mem_we", mem_we, 0);   chk("rst_mem_a", mem_a, 0);
      chk("rst_mem_wd", mem_wd, 0);

      // Directed table
      for (int k = 0; k < 8; k++)
         txn(tbl[k].port_d, tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].exp);

      // Fetch while d_rdata holds 0x12345678: txn checks d_rdata and d_rvalid stay put
      txn(0, 0, 32'h20, 32'h0, 32'hDEADBEEF);

      // Ties right after reset, then repeated
      apply_reset();
      tie();
      tie();

      // Four back-to-back loads in eight cycles
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("b2b_gnt", d_gnt, 1);
         chk("b2b_mem_a", mem_a, 32'h100 + 32'(4 * k));
         if (k < 3) d_addr = 32'h100 + 32'(4 * (k + 1));
         else       d_req = 1'b0;
         @(negedge clk);
         chk("b2b_rvalid", d_rvalid, 1);
         chk("b2b_resp_gnt", d_gnt, 0);
         chk("b2b_rdata", d_rdata, 32'h1111_0000 + 32'(k));
      end
      d_hold = 32'h1111_0003; rr_last = PORT_D;

      // Reset during the ACCESS cycle of a store
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h60; d_wdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("rma_gnt", d_gnt, 1);
      chk("rma_we", mem_we, 1);
      d_req = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("rma_we_off", mem_we, 0);
      chk("rma_gnt_off", d_gnt, 0);
      chk("rma_rvalid_off", d_rvalid, 0);
      @(negedge clk);
      reset = 1'b0;
      rr_last = PORT_D; i_hold = '0; d_hold = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rma_no_rvalid", d_rvalid | i_rvalid, 0);
         chk("rma_idle_we", mem_we, 0);
      end
      txn(1, 0, 32'h20, 32'h0, 32'hDEADBEEF);

      // Randomized traffic against the reference model
      apply_reset();
      for (int k = 0; k < 256; k++) ref_mem[k] = mem[k];
      rv_due = 1'b0; rv_port = PORT_I; rv_we = 1'b0; rv_addr = '0; rv_wd = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         chk("rnd_i_rvalid", i_rvalid, rv_due && rv_port == PORT_I);
         chk("rnd_d_rvalid", d_rvalid, rv_due && rv_port == PORT_D);
         if (rv_due) begin
            if (rv_we)                 ref_mem[rv_addr[9:2]] = rv_wd;
            else if (rv_port == PORT_I) i_hold = ref_mem[rv_addr[9:2]];
            else                        d_hold = ref_mem[rv_addr[9:2]];
         end
         chk("rnd_i_rdata", i_rdata, i_hold);
         chk("rnd_d_rdata", d_rdata, d_hold);
         rv_due = 1'b0;
         gi = i_gnt; gd = d_gnt;
         chk("rnd_gnt_excl", gi & gd, 0);
         if (gi | gd) begin
            w = gd ? PORT_D : PORT_I;
            chk("rnd_gnt_req", gd ? d_req : i_req, 1);
            if (i_req && d_req) begin
               ew = tie_winner(rr_last);
               chk("rnd_tie", w, ew);
            end
            rr_last = w;
            rv_due  = 1'b1;
            rv_port = w;
            rv_we   = gd ? d_we : 1'b0;
            rv_addr = gd ? d_addr : i_addr;
            rv_wd   = d_wdata;
            chk("rnd_mem_we", mem_we, rv_we);
            chk("rnd_mem_a", mem_a, rv_addr);
            if (rv_we) chk("rnd_mem_wd", mem_wd, rv_wd);
         end else begin
            chk("rnd_idle_we", mem_we, 0);
         end
         // Requesters: hold until granted, then drop or present the next command
         if (i_req ? (gi && $urandom_range(1, 0) == 1) : ($urandom_range(9, 0) < 4)) begin
            i_req = 1'b1; i_addr = 32'($urandom_range(63, 0));
         end else if (gi) begin
            i_req = 1'b0;
         end
         if (d_req ? (gd && $urandom_range(1, 0) == 1) : ($urandom_range(9, 0) < 4)) begin
            d_req = 1'b1; d_we = 1'($urandom_range(1, 0));
            d_addr = 32'($urandom_range(63, 0)); d_wdata = $urandom;
         end else if (gd) begin
            d_req = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
